pc_sequencer: RTL and testbench

Next-PC controller for the PC register. It drives `next_pc` every cycle, since the PC register loads unconditionally on each clock edge. It sequences instruction fetch through a request/ready handshake with instruction memory. It arbitrates the sequential, branch, jump, trap-entry and trap-return address sources, and tracks trap state (EPC, cause, in_trap), HALT and a memory-timeout fault.

---
 rtl/pc_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequences instruction fetch, arbitrates the PC sources
// and tracks trap state (EPC, cause, in_trap), HALT and memory-timeout faults.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          PC_STEP      = 4,
    parameter int          MEM_TIMEOUT  = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] current_pc_i,
    output logic [31:0] next_pc_o,
    output logic        imem_req_o,
    input  logic        imem_ready_i,
    output logic        instr_valid_o,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        exception_i,
    input  logic        irq_i,
    input  logic        irq_enable_i,
    input  logic        mret_i,
    input  logic        halt_i,
    output logic [31:0] epc_o,
    output logic [1:0]  cause_o,
    output logic        in_trap_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        WAIT_MEM = 2'b01,
        TRAP     = 2'b10,
        HALT     = 2'b11
    } stateT;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_IRQ  = 2'b01;
    localparam logic [1:0] CAUSE_EXC  = 2'b10;
    localparam logic [1:0] CAUSE_BUS  = 2'b11;

    stateT         state_q, state_d;
    logic [31:0]   epc_q, epc_d;
    logic [1:0]    cause_q, cause_d;
    logic          inTrap_q, inTrap_d;
    logic          irqPending_q, irqPending_d;
    logic [CW-1:0] waitCnt_q, waitCnt_d;

    logic          fetchDone;
    logic          trapEntry;
    logic [1:0]    trapCause;
    logic [31:0]   pcPlus;

    assign pcPlus = current_pc_i + 32'(PC_STEP);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= RUN;
            epc_q        <= 32'h0;
            cause_q      <= CAUSE_NONE;
            inTrap_q     <= 1'b0;
            irqPending_q <= 1'b0;
            waitCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            inTrap_q     <= inTrap_d;
            irqPending_q <= irqPending_d;
            waitCnt_q    <= waitCnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        inTrap_d      = inTrap_q;
        irqPending_d  = irqPending_q | irq_i;
        waitCnt_d     = waitCnt_q;
        next_pc_o     = current_pc_i;
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
        fetchDone     = 1'b0;
        trapEntry     = 1'b0;
        trapCause     = CAUSE_NONE;

        case (state_q)
            RUN: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    fetchDone = 1'b1;
                end else begin
                    state_d   = WAIT_MEM;
                    waitCnt_d = CW'(1);
                end
            end
            WAIT_MEM: begin
                imem_req_o = 1'b1;
                waitCnt_d  = waitCnt_q + CW'(1);
                if (imem_ready_i) begin
                    fetchDone = 1'b1;
                    state_d   = RUN;
                end else if (waitCnt_q == CW'(MEM_TIMEOUT)) begin
                    // A bus fault inside the handler cannot be recovered.
                    if (inTrap_q) begin
                        state_d = HALT;
                    end else begin
                        trapEntry = 1'b1;
                        trapCause = CAUSE_BUS;
                    end
                end
            end
            TRAP: begin
                state_d = RUN;
            end
            HALT: begin
                if (irqPending_q && irq_enable_i) begin
                    trapEntry = 1'b1;
                    trapCause = CAUSE_IRQ;
                end
            end
            default: state_d = RUN;
        endcase

        if (fetchDone) begin
            if (exception_i) begin
                if (inTrap_q) begin
                    state_d = HALT;
                end else begin
                    trapEntry = 1'b1;
                    trapCause = CAUSE_EXC;
                end
            end else if (irqPending_q && irq_enable_i && !inTrap_q) begin
                trapEntry = 1'b1;
                trapCause = CAUSE_IRQ;
            end else if (mret_i && inTrap_q) begin
                next_pc_o     = epc_q;
                inTrap_d      = 1'b0;
                cause_d       = CAUSE_NONE;
                instr_valid_o = 1'b1;
            end else if (jump_i) begin
                next_pc_o     = jump_target_i;
                instr_valid_o = 1'b1;
            end else if (branch_taken_i) begin
                next_pc_o     = branch_target_i;
                instr_valid_o = 1'b1;
            end else if (stall_i) begin
                next_pc_o = current_pc_i;
            end else if (halt_i) begin
                next_pc_o     = pcPlus;
                instr_valid_o = 1'b1;
                state_d       = HALT;
            end else begin
                next_pc_o     = pcPlus;
                instr_valid_o = 1'b1;
            end
        end

        // An irq trap consumes the pending request even if irq is still high.
        if (trapEntry) begin
            next_pc_o     = TRAP_VECTOR;
            epc_d         = current_pc_i;
            inTrap_d      = 1'b1;
            cause_d       = trapCause;
            instr_valid_o = 1'b0;
            state_d       = TRAP;
            if (trapCause == CAUSE_IRQ) begin
                irqPending_d = 1'b0;
            end
        end

        if (reset_i) begin
            next_pc_o     = RESET_VECTOR;
            imem_req_o    = 1'b0;
            instr_valid_o = 1'b0;
        end
    end

    assign epc_o     = epc_q;
    assign cause_o   = cause_q;
    assign in_trap_o = inTrap_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: the bench plays the PC register by hand,
// driving current_pc with the value the previous step expected on next_pc.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] currentPc;
    logic [31:0] nextPc;
    logic        imemReq;
    logic        imemReady;
    logic        instrValid;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [31:0] jumpTarget;
    logic        exceptionIn;
    logic        irq;
    logic        irqEnable;
    logic        mret;
    logic        halt;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        inTrap;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0100),
        .PC_STEP     (4),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .current_pc_i   (currentPc),
        .next_pc_o      (nextPc),
        .imem_req_o     (imemReq),
        .imem_ready_i   (imemReady),
        .instr_valid_o  (instrValid),
        .stall_i        (stall),
        .branch_taken_i (branchTaken),
        .branch_target_i(branchTarget),
        .jump_i         (jump),
        .jump_target_i  (jumpTarget),
        .exception_i    (exceptionIn),
        .irq_i          (irq),
        .irq_enable_i   (irqEnable),
        .mret_i         (mret),
        .halt_i         (halt),
        .epc_o          (epc),
        .cause_o        (cause),
        .in_trap_o      (inTrap),
        .state_o        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sets the PC and memory readiness for a step and clears every event input.
    task automatic applyStimulus(input logic [31:0] pc, input logic ready);
        currentPc    = pc;
        imemReady    = ready;
        stall        = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = 32'h0;
        jump         = 1'b0;
        jumpTarget   = 32'h0;
        exceptionIn  = 1'b0;
        irq          = 1'b0;
        irqEnable    = 1'b0;
        mret         = 1'b0;
        halt         = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: combinational outputs forced, registers cleared at the edge.
        reset = 1'b1;
        applyStimulus(32'h1234, 1'b1);
        jump       = 1'b1;
        jumpTarget = 32'h8888;
        #1;
        checkOutput("rst_next_pc", nextPc, 32'h0);
        checkOutput("rst_req", {31'b0, imemReq}, 32'h0);
        checkOutput("rst_valid", {31'b0, instrValid}, 32'h0);
        tick();
        checkOutput("rst_state", {30'b0, state}, 32'h0);
        checkOutput("rst_epc", epc, 32'h0);
        checkOutput("rst_cause", {30'b0, cause}, 32'h0);
        checkOutput("rst_in_trap", {31'b0, inTrap}, 32'h0);
        reset = 1'b0;

        // Sequential fetch 0 -> 4 -> 8 -> 12.
        applyStimulus(32'h0, 1'b1); #1;
        checkOutput("seq0_next", nextPc, 32'h4);
        checkOutput("seq0_valid", {31'b0, instrValid}, 32'h1);
        checkOutput("seq0_req", {31'b0, imemReq}, 32'h1);
        tick();
        applyStimulus(32'h4, 1'b1); #1;
        checkOutput("seq1_next", nextPc, 32'h8);
        tick();
        applyStimulus(32'h8, 1'b1); #1;
        checkOutput("seq2_next", nextPc, 32'hC);
        checkOutput("seq2_state", {30'b0, state}, 32'h0);
        tick();

        // Memory wait: ready low for three cycles at 0x20.
        applyStimulus(32'h20, 1'b0); #1;
        checkOutput("wait0_next", nextPc, 32'h20);
        checkOutput("wait0_valid", {31'b0, instrValid}, 32'h0);
        tick();
        checkOutput("wait1_state", {30'b0, state}, 32'h1);
        applyStimulus(32'h20, 1'b0); #1;
        checkOutput("wait1_next", nextPc, 32'h20);
        checkOutput("wait1_req", {31'b0, imemReq}, 32'h1);
        tick();
        applyStimulus(32'h20, 1'b0); #1;
        checkOutput("wait2_valid", {31'b0, instrValid}, 32'h0);
        tick();
        applyStimulus(32'h20, 1'b1); #1;
        checkOutput("wait_done_next", nextPc, 32'h24);
        checkOutput("wait_done_valid", {31'b0, instrValid}, 32'h1);
        tick();
        checkOutput("wait_done_state", {30'b0, state}, 32'h0);

        // Jump beats branch; exception beats both.
        applyStimulus(32'h40, 1'b1);
        jump         = 1'b1;
        jumpTarget   = 32'h80;
        branchTaken  = 1'b1;
        branchTarget = 32'hC0;
        #1;
        checkOutput("jmp_vs_br_next", nextPc, 32'h80);
        exceptionIn = 1'b1;
        #1;
        checkOutput("exc_next", nextPc, 32'h100);
        checkOutput("exc_valid", {31'b0, instrValid}, 32'h0);
        tick();
        checkOutput("exc_state", {30'b0, state}, 32'h2);
        checkOutput("exc_epc", epc, 32'h40);
        checkOutput("exc_cause", {30'b0, cause}, 32'h2);
        checkOutput("exc_in_trap", {31'b0, inTrap}, 32'h1);
        applyStimulus(32'h100, 1'b1);
        jump       = 1'b1;
        jumpTarget = 32'h80;
        #1;
        checkOutput("trap_bubble_req", {31'b0, imemReq}, 32'h0);
        checkOutput("trap_bubble_next", nextPc, 32'h100);
        tick();
        applyStimulus(32'h100, 1'b1);
        mret = 1'b1;
        #1;
        checkOutput("mret_exc_next", nextPc, 32'h40);
        checkOutput("mret_exc_valid", {31'b0, instrValid}, 32'h1);
        tick();
        checkOutput("mret_exc_in_trap", {31'b0, inTrap}, 32'h0);
        checkOutput("mret_exc_cause", {30'b0, cause}, 32'h0);

        // Interrupt latched while disabled, taken once enabled at 0x30.
        applyStimulus(32'h40, 1'b1);
        irq = 1'b1;
        #1;
        checkOutput("irq_masked_next", nextPc, 32'h44);
        tick();
        applyStimulus(32'h44, 1'b1); #1;
        checkOutput("irq_pend_next", nextPc, 32'h48);
        tick();
        applyStimulus(32'h30, 1'b1);
        irqEnable = 1'b1;
        #1;
        checkOutput("irq_take_next", nextPc, 32'h100);
        tick();
        checkOutput("irq_epc", epc, 32'h30);
        checkOutput("irq_cause", {30'b0, cause}, 32'h1);
        applyStimulus(32'h100, 1'b1); #1;
        tick();
        applyStimulus(32'h100, 1'b1);
        irqEnable = 1'b1;
        #1;
        checkOutput("handler_next", nextPc, 32'h104);
        tick();
        applyStimulus(32'h104, 1'b1);
        mret = 1'b1;
        #1;
        checkOutput("mret_irq_next", nextPc, 32'h30);
        tick();
        checkOutput("mret_irq_in_trap", {31'b0, inTrap}, 32'h0);
        applyStimulus(32'h30, 1'b1);
        irqEnable = 1'b1;
        #1;
        checkOutput("irq_cleared_next", nextPc, 32'h34);
        tick();

        // Stall, stall overridden by branch, mret outside a trap, wraparound.
        applyStimulus(32'h60, 1'b1);
        stall = 1'b1;
        #1;
        checkOutput("stall_next", nextPc, 32'h60);
        checkOutput("stall_valid", {31'b0, instrValid}, 32'h0);
        branchTaken  = 1'b1;
        branchTarget = 32'hC0;
        #1;
        checkOutput("br_over_stall_next", nextPc, 32'hC0);
        tick();
        applyStimulus(32'h60, 1'b1);
        mret = 1'b1;
        #1;
        checkOutput("mret_nop_next", nextPc, 32'h64);
        tick();
        applyStimulus(32'hFFFF_FFFC, 1'b1); #1;
        checkOutput("wrap_next", nextPc, 32'h0);
        tick();

        // Bus fault after the timeout, then a second one inside the handler.
        applyStimulus(32'h50, 1'b0); #1;
        tick();
        for (int i = 1; i < 16; i++) begin
            applyStimulus(32'h50, 1'b0); #1;
            checkOutput($sformatf("tmo_wait%0d_next", i), nextPc, 32'h50);
            tick();
        end
        applyStimulus(32'h50, 1'b0); #1;
        checkOutput("tmo_fault_next", nextPc, 32'h100);
        tick();
        checkOutput("tmo_cause", {30'b0, cause}, 32'h3);
        checkOutput("tmo_epc", epc, 32'h50);
        checkOutput("tmo_state", {30'b0, state}, 32'h2);
        applyStimulus(32'h100, 1'b1); #1;
        tick();
        applyStimulus(32'h100, 1'b0); #1;
        tick();
        for (int i = 1; i < 16; i++) begin
            applyStimulus(32'h100, 1'b0); #1;
            tick();
        end
        applyStimulus(32'h100, 1'b0); #1;
        checkOutput("tmo2_next", nextPc, 32'h100);
        tick();
        checkOutput("tmo2_state", {30'b0, state}, 32'h3);
        checkOutput("tmo2_cause", {30'b0, cause}, 32'h3);
        applyStimulus(32'h100, 1'b1); #1;
        checkOutput("halt_req", {31'b0, imemReq}, 32'h0);
        checkOutput("halt_valid", {31'b0, instrValid}, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("tmo_rst_in_trap", {31'b0, inTrap}, 32'h0);

        // Halt instruction, wake by interrupt, then reset during a memory wait.
        applyStimulus(32'h10, 1'b1);
        halt = 1'b1;
        #1;
        checkOutput("halt_instr_next", nextPc, 32'h14);
        checkOutput("halt_instr_valid", {31'b0, instrValid}, 32'h1);
        tick();
        checkOutput("halt_state", {30'b0, state}, 32'h3);
        applyStimulus(32'h14, 1'b1); #1;
        checkOutput("halt_hold_next", nextPc, 32'h14);
        applyStimulus(32'h14, 1'b1);
        irq       = 1'b1;
        irqEnable = 1'b1;
        #1;
        checkOutput("halt_irq_latch_next", nextPc, 32'h14);
        tick();
        applyStimulus(32'h14, 1'b1);
        irqEnable = 1'b1;
        #1;
        checkOutput("halt_wake_next", nextPc, 32'h100);
        tick();
        checkOutput("halt_wake_epc", epc, 32'h14);
        checkOutput("halt_wake_cause", {30'b0, cause}, 32'h1);
        applyStimulus(32'h100, 1'b1); #1;
        tick();
        applyStimulus(32'h100, 1'b0); #1;
        tick();
        checkOutput("pre_rst_state", {30'b0, state}, 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("rst_wait_next", nextPc, 32'h0);
        checkOutput("rst_wait_req", {31'b0, imemReq}, 32'h0);
        tick();
        reset = 1'b0;
        checkOutput("rst_wait_state", {30'b0, state}, 32'h0);
        checkOutput("rst_wait_epc", epc, 32'h0);
        checkOutput("rst_wait_cause", {30'b0, cause}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
